// File: rtl/wb_regfile.sv
// wb_regfile: writeback register file with two bypassed combinational read
// ports and a load scoreboard that stalls on operands still in flight.
module wb_regfile #(
    parameter int NREG = 32,
    parameter int DW   = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wb_en,
    input  logic [4:0]    wb_rd,
    input  logic [DW-1:0] wb_data,
    input  logic [4:0]    rs1_addr,
    input  logic [4:0]    rs2_addr,
    output logic [DW-1:0] rs1_data,
    output logic [DW-1:0] rs2_data,
    input  logic          ld_issue,
    input  logic [4:0]    ld_rd,
    output logic          stall,
    output logic [5:0]    pending_cnt
);

    localparam int NPORT = 2;

    // Entry 0 of both arrays is never written, so it stays at its reset
    // value of zero and synthesis folds it into a constant. Keeping the full
    // 0..NREG-1 range lets any 5-bit address index the arrays directly.
    logic [NREG-1:0][DW-1:0] regs_q, regs_d;
    logic [NREG-1:0]         busy_q, busy_d;
    logic [5:0]              pending_cnt_q, pending_cnt_d;

    logic [NPORT-1:0][4:0]    rs_addr;
    logic [NPORT-1:0][DW-1:0] rs_dat;
    logic [NPORT-1:0]         hz;

    logic wr_fire;
    logic ld_fire;
    logic cnt_inc;
    logic cnt_dec;

    assign rs_addr  = {rs2_addr, rs1_addr};
    assign rs1_data = rs_dat[0];
    assign rs2_data = rs_dat[1];
    assign stall    = |hz;
    assign pending_cnt = pending_cnt_q;

    // Read ports: r0 is zero, a same-cycle writeback bypasses the array,
    // and a busy operand is a hazard unless that writeback resolves it now.
    always_comb begin
        rs_dat = '0;
        hz     = '0;
        for (int p = 0; p < NPORT; p++) begin
            if (rs_addr[p] == 5'd0) begin
                rs_dat[p] = '0;
                hz[p]     = 1'b0;
            end else if (wb_en && (wb_rd == rs_addr[p])) begin
                rs_dat[p] = wb_data;
                hz[p]     = 1'b0;
            end else begin
                rs_dat[p] = regs_q[rs_addr[p]];
                hz[p]     = busy_q[rs_addr[p]];
            end
        end
    end

    // Next-state for registers, scoreboard and its running popcount.
    // A load issued under stall is held upstream, so it is ignored here.
    always_comb begin
        wr_fire = wb_en && (wb_rd != 5'd0);
        ld_fire = ld_issue && (ld_rd != 5'd0) && !stall;

        regs_d = regs_q;
        if (wr_fire) regs_d[wb_rd] = wb_data;

        // Clear before set so a same-register set/clear leaves busy at 1.
        busy_d = busy_q;
        if (wr_fire) busy_d[wb_rd] = 1'b0;
        if (ld_fire) busy_d[ld_rd] = 1'b1;

        // Count only real bit transitions so the counter tracks busy exactly.
        cnt_inc = ld_fire && !busy_q[ld_rd];
        cnt_dec = wr_fire && busy_q[wb_rd] && !(ld_fire && (ld_rd == wb_rd));
        pending_cnt_d = pending_cnt_q;
        if (cnt_inc && !cnt_dec)      pending_cnt_d = pending_cnt_q + 6'd1;
        else if (cnt_dec && !cnt_inc) pending_cnt_d = pending_cnt_q - 6'd1;
    end

    // State registers; reset drops all contents and outstanding loads at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q        <= '0;
            busy_q        <= '0;
            pending_cnt_q <= '0;
        end else begin
            regs_q        <= regs_d;
            busy_q        <= busy_d;
            pending_cnt_q <= pending_cnt_d;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: one task per scenario, inline checks.
module tb_wb_regfile;

    logic        clk;
    logic        rst_n;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        ld_issue;
    logic [4:0]  ld_rd;
    logic        stall;
    logic [5:0]  pending_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    wb_regfile #(.NREG(32), .DW(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb_en      (wb_en),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .ld_issue   (ld_issue),
        .ld_rd      (ld_rd),
        .stall      (stall),
        .pending_cnt(pending_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance past the next rising edge; inputs change away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_en = 0; wb_rd = 0; wb_data = 0;
        ld_issue = 0; ld_rd = 0;
        rs1_addr = 0; rs2_addr = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle();
        tick();
        rst_n = 1;
        tick();
        wb_en = 1; wb_rd = 5; wb_data = 32'hDEADBEEF;
        tick();
        wb_en = 0; rs1_addr = 5;
        #1;
        n_cmp++;
        if (rs1_data !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL reset_prewrite: got %h want %h", rs1_data, 32'hDEADBEEF);
        end
        rst_n = 0;
        #1;
        n_cmp++;
        if (rs1_data !== 32'h0) begin
            n_bad++; $display("FAIL reset_rs1: got %h want %h", rs1_data, 32'h0);
        end
        n_cmp++;
        if (stall !== 1'b0) begin
            n_bad++; $display("FAIL reset_stall: got %b want 0", stall);
        end
        n_cmp++;
        if (pending_cnt !== 6'd0) begin
            n_bad++; $display("FAIL reset_cnt: got %0d want 0", pending_cnt);
        end
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_write_read();
        idle();
        wb_en = 1; wb_rd = 7; wb_data = 32'h12345678; rs1_addr = 7;
        #1;
        n_cmp++;
        if (rs1_data !== 32'h12345678) begin
            n_bad++; $display("FAIL bypass_rs1: got %h want %h", rs1_data, 32'h12345678);
        end
        tick();
        wb_en = 0; rs2_addr = 7;
        #1;
        n_cmp++;
        if (rs1_data !== 32'h12345678) begin
            n_bad++; $display("FAIL array_rs1: got %h want %h", rs1_data, 32'h12345678);
        end
        n_cmp++;
        if (rs2_data !== 32'h12345678) begin
            n_bad++; $display("FAIL array_rs2_same: got %h want %h", rs2_data, 32'h12345678);
        end
        // Bypass overrides a stale array value on one port only.
        wb_en = 1; wb_rd = 7; wb_data = 32'hCAFEF00D; rs1_addr = 7; rs2_addr = 5;
        #1;
        n_cmp++;
        if (rs1_data !== 32'hCAFEF00D) begin
            n_bad++; $display("FAIL bypass_over: got %h want %h", rs1_data, 32'hCAFEF00D);
        end
        n_cmp++;
        if (rs2_data !== 32'h0) begin
            n_bad++; $display("FAIL rs2_r5_cleared: got %h want %h", rs2_data, 32'h0);
        end
        tick();
        wb_en = 1; wb_rd = 0; wb_data = 32'hFFFFFFFF; rs2_addr = 0;
        #1;
        n_cmp++;
        if (rs2_data !== 32'h0) begin
            n_bad++; $display("FAIL r0_bypass: got %h want %h", rs2_data, 32'h0);
        end
        tick();
        wb_en = 0;
        #1;
        n_cmp++;
        if (rs2_data !== 32'h0) begin
            n_bad++; $display("FAIL r0_array: got %h want %h", rs2_data, 32'h0);
        end
        n_cmp++;
        if (rs1_data !== 32'hCAFEF00D) begin
            n_bad++; $display("FAIL r7_after: got %h want %h", rs1_data, 32'hCAFEF00D);
        end
    endtask

    task automatic test_load_hazard();
        idle();
        ld_issue = 1; ld_rd = 9;
        tick();
        ld_issue = 0; rs2_addr = 9;
        #1;
        n_cmp++;
        if (stall !== 1'b1) begin
            n_bad++; $display("FAIL hz_stall: got %b want 1", stall);
        end
        n_cmp++;
        if (pending_cnt !== 6'd1) begin
            n_bad++; $display("FAIL hz_cnt: got %0d want 1", pending_cnt);
        end
        wb_en = 1; wb_rd = 9; wb_data = 32'hA5A5A5A5;
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_bad++; $display("FAIL hz_wb_stall: got %b want 0", stall);
        end
        n_cmp++;
        if (rs2_data !== 32'hA5A5A5A5) begin
            n_bad++; $display("FAIL hz_wb_data: got %h want %h", rs2_data, 32'hA5A5A5A5);
        end
        tick();
        wb_en = 0;
        #1;
        n_cmp++;
        if (pending_cnt !== 6'd0) begin
            n_bad++; $display("FAIL hz_cnt_after: got %0d want 0", pending_cnt);
        end
        n_cmp++;
        if (stall !== 1'b0) begin
            n_bad++; $display("FAIL hz_stall_after: got %b want 0", stall);
        end
        // A load to r0 is dropped.
        ld_issue = 1; ld_rd = 0;
        tick();
        ld_issue = 0;
        #1;
        n_cmp++;
        if (pending_cnt !== 6'd0) begin
            n_bad++; $display("FAIL ld_r0_cnt: got %0d want 0", pending_cnt);
        end
    endtask

    task automatic test_set_clear();
        idle();
        ld_issue = 1; ld_rd = 4;
        tick();
        ld_issue = 1; ld_rd = 4; wb_en = 1; wb_rd = 4; wb_data = 32'h44;
        tick();
        idle(); rs1_addr = 4;
        #1;
        n_cmp++;
        if (pending_cnt !== 6'd1) begin
            n_bad++; $display("FAIL sc_cnt: got %0d want 1", pending_cnt);
        end
        n_cmp++;
        if (stall !== 1'b1) begin
            n_bad++; $display("FAIL sc_busy: got %b want 1", stall);
        end
        // Set r10 and clear r4 on one edge: net zero.
        rs1_addr = 0;
        ld_issue = 1; ld_rd = 10; wb_en = 1; wb_rd = 4; wb_data = 32'h55;
        tick();
        idle(); rs1_addr = 4; rs2_addr = 10;
        #1;
        n_cmp++;
        if (pending_cnt !== 6'd1) begin
            n_bad++; $display("FAIL sc_mixed_cnt: got %0d want 1", pending_cnt);
        end
        n_cmp++;
        if (rs1_data !== 32'h55) begin
            n_bad++; $display("FAIL sc_r4_data: got %h want %h", rs1_data, 32'h55);
        end
        n_cmp++;
        if (stall !== 1'b1) begin
            n_bad++; $display("FAIL sc_r10_busy: got %b want 1", stall);
        end
        // Writeback to a non-busy register does not decrement.
        rs1_addr = 0; rs2_addr = 0;
        wb_en = 1; wb_rd = 20; wb_data = 32'h20;
        tick();
        wb_en = 1; wb_rd = 10; wb_data = 32'h10;
        tick();
        idle();
        #1;
        n_cmp++;
        if (pending_cnt !== 6'd0) begin
            n_bad++; $display("FAIL sc_final_cnt: got %0d want 0", pending_cnt);
        end
    endtask

    task automatic test_issue_during_stall();
        idle();
        ld_issue = 1; ld_rd = 11;
        tick();
        ld_issue = 1; ld_rd = 12; rs1_addr = 11;
        #1;
        n_cmp++;
        if (stall !== 1'b1) begin
            n_bad++; $display("FAIL ids_stall: got %b want 1", stall);
        end
        tick();
        idle(); rs1_addr = 12;
        #1;
        n_cmp++;
        if (pending_cnt !== 6'd1) begin
            n_bad++; $display("FAIL ids_cnt: got %0d want 1", pending_cnt);
        end
        n_cmp++;
        if (stall !== 1'b0) begin
            n_bad++; $display("FAIL ids_r12_busy: got %b want 0", stall);
        end
        rs1_addr = 0;
        wb_en = 1; wb_rd = 11; wb_data = 32'h11;
        tick();
        idle();
    endtask

    task automatic test_async_reset();
        idle();
        ld_issue = 1; ld_rd = 3;
        tick();
        ld_issue = 1; ld_rd = 8;
        tick();
        idle(); rs1_addr = 3;
        #1;
        n_cmp++;
        if (pending_cnt !== 6'd2) begin
            n_bad++; $display("FAIL ar_cnt_pre: got %0d want 2", pending_cnt);
        end
        n_cmp++;
        if (stall !== 1'b1) begin
            n_bad++; $display("FAIL ar_stall_pre: got %b want 1", stall);
        end
        @(negedge clk);
        #1;
        rst_n = 0;
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_bad++; $display("FAIL ar_stall: got %b want 0", stall);
        end
        n_cmp++;
        if (pending_cnt !== 6'd0) begin
            n_bad++; $display("FAIL ar_cnt: got %0d want 0", pending_cnt);
        end
        rs1_addr = 7;
        #1;
        n_cmp++;
        if (rs1_data !== 32'h0) begin
            n_bad++; $display("FAIL ar_r7: got %h want %h", rs1_data, 32'h0);
        end
        tick();
        rst_n = 1;
        wb_en = 1; wb_rd = 2; wb_data = 32'h0BADF00D;
        tick();
        idle(); rs2_addr = 2;
        #1;
        n_cmp++;
        if (rs2_data !== 32'h0BADF00D) begin
            n_bad++; $display("FAIL ar_first_write: got %h want %h", rs2_data, 32'h0BADF00D);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_load_hazard();
        test_set_clear();
        test_issue_during_stall();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
